// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3x3 signed-kernel MAC over unsigned pixel windows, shift/saturate, pack 4 bytes/word.
// Define CONV_RELU_EN for unsigned ReLU clamping (0x00..0xFF); default is signed saturation (0x80..0x7F).
module conv3x3_mac #(
  parameter int SHIFT      = 4,
  parameter int PIPE_SUM_W = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_load_en,
  input  logic [31:0] w_data,
  output logic        w_ready,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [23:0] x_top,
  input  logic [23:0] x_mid,
  input  logic [23:0] x_bot,
  output logic [31:0] out_word,
  output logic        out_word_valid,
  output logic        out_row_done,
  output logic        busy
);

  localparam int PROD_W = 17;

`ifdef CONV_RELU_EN
  localparam logic signed [PIPE_SUM_W-1:0] SUM_ZERO   = PIPE_SUM_W'(0);
  localparam logic signed [PIPE_SUM_W-1:0] SUM_U8_MAX = PIPE_SUM_W'(255);
`else
  localparam logic signed [PIPE_SUM_W-1:0] SUM_S8_MIN = PIPE_SUM_W'(-128);
  localparam logic signed [PIPE_SUM_W-1:0] SUM_S8_MAX = PIPE_SUM_W'(127);
`endif

  // Unsigned pixel times signed weight; both widened to the product width first.
  function automatic logic signed [PROD_W-1:0] mul_px(input logic [7:0] px, input logic [7:0] wt);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = {{(PROD_W-8){1'b0}}, px};
    b = {{(PROD_W-8){wt[7]}}, wt};
    return a * b;
  endfunction

  function automatic logic signed [PIPE_SUM_W-1:0] sext(input logic signed [PROD_W-1:0] p);
    return {{(PIPE_SUM_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic [7:0] sat_byte(input logic signed [PIPE_SUM_W-1:0] v);
    logic [7:0] b;
`ifdef CONV_RELU_EN
    if (v < SUM_ZERO) begin
      b = 8'h00;
    end else if (v > SUM_U8_MAX) begin
      b = 8'hFF;
    end else begin
      b = v[7:0];
    end
`else
    if (v < SUM_S8_MIN) begin
      b = 8'h80;
    end else if (v > SUM_S8_MAX) begin
      b = 8'h7F;
    end else begin
      b = v[7:0];
    end
`endif
    return b;
  endfunction

  logic [7:0]                    k_r [9];
  logic [1:0]                    w_count_r;
  logic                          w_ready_r;
  logic [71:0]                   x_all_s;
  logic signed [PROD_W-1:0]      prod_s [9];
  logic                          s1_v_r;
  logic                          s1_last_r;
  logic signed [PROD_W-1:0]      s1_prod_r [9];
  logic signed [PIPE_SUM_W-1:0]  row_sum_s [3];
  logic                          s2_v_r;
  logic                          s2_last_r;
  logic signed [PIPE_SUM_W-1:0]  s2_row_r [3];
  logic signed [PIPE_SUM_W-1:0]  total_s;
  logic signed [PIPE_SUM_W-1:0]  shifted_s;
  logic                          s3_v_r;
  logic                          s3_last_r;
  logic [7:0]                    s3_byte_r;
  logic [1:0]                    pk_idx_r;
  logic [31:0]                   pk_word_r;
  logic [31:0]                   ins_word_s;
  logic [31:0]                   merged_s;
  logic                          flush_s;
  logic [31:0]                   out_word_r;
  logic                          out_word_valid_r;
  logic                          out_row_done_r;
  logic                          unused_s;

  assign unused_s = ^w_data[31:24];

  // Kernel row write port: rows fill 0,1,2 then wrap; ready only after a full set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) k_r[i] <= 8'h00;
      w_count_r <= 2'd0;
      w_ready_r <= 1'b0;
    end else if (w_load_en) begin
      case (w_count_r)
        2'd0: begin
          k_r[0] <= w_data[7:0];
          k_r[1] <= w_data[15:8];
          k_r[2] <= w_data[23:16];
        end
        2'd1: begin
          k_r[3] <= w_data[7:0];
          k_r[4] <= w_data[15:8];
          k_r[5] <= w_data[23:16];
        end
        2'd2: begin
          k_r[6] <= w_data[7:0];
          k_r[7] <= w_data[15:8];
          k_r[8] <= w_data[23:16];
        end
        default: begin
          k_r[0] <= k_r[0];
        end
      endcase
      w_count_r <= (w_count_r == 2'd2) ? 2'd0 : w_count_r + 2'd1;
      w_ready_r <= (w_count_r == 2'd2);
    end
  end

  // Nine products; pixel i and weight i share the same row-major position.
  always_comb begin
    x_all_s = {x_bot, x_mid, x_top};
    for (int i = 0; i < 9; i++) begin
      prod_s[i] = mul_px(x_all_s[8*i +: 8], k_r[i]);
    end
  end

  // S1 register: products are frozen here, so later kernel writes do not affect this window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_r    <= 1'b0;
      s1_last_r <= 1'b0;
      for (int i = 0; i < 9; i++) s1_prod_r[i] <= '0;
    end else begin
      s1_v_r    <= in_valid;
      s1_last_r <= in_valid & in_last;
      if (in_valid) begin
        for (int i = 0; i < 9; i++) s1_prod_r[i] <= prod_s[i];
      end
    end
  end

  // Per-row sums of the three products.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_sum_s[r] = sext(s1_prod_r[3*r]) + sext(s1_prod_r[3*r+1]) + sext(s1_prod_r[3*r+2]);
    end
  end

  // S2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_r    <= 1'b0;
      s2_last_r <= 1'b0;
      for (int r = 0; r < 3; r++) s2_row_r[r] <= '0;
    end else begin
      s2_v_r    <= s1_v_r;
      s2_last_r <= s1_last_r;
      if (s1_v_r) begin
        for (int r = 0; r < 3; r++) s2_row_r[r] <= row_sum_s[r];
      end
    end
  end

  // Window total, arithmetic shift (floor), then saturation.
  always_comb begin
    total_s   = s2_row_r[0] + s2_row_r[1] + s2_row_r[2];
    shifted_s = total_s >>> SHIFT;
  end

  // S3 register holds the final byte and its end-of-row tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_v_r    <= 1'b0;
      s3_last_r <= 1'b0;
      s3_byte_r <= 8'h00;
    end else begin
      s3_v_r    <= s2_v_r;
      s3_last_r <= s2_last_r;
      if (s2_v_r) begin
        s3_byte_r <= sat_byte(shifted_s);
      end
    end
  end

  // Merge the S3 byte into the partial word at the current lane.
  always_comb begin
    ins_word_s = {24'h000000, s3_byte_r} << {pk_idx_r, 3'b000};
    merged_s   = pk_word_r | ins_word_s;
    flush_s    = s3_v_r & ((pk_idx_r == 2'd3) | s3_last_r);
  end

  // Packer: emit on the fourth byte or on a row-ending byte; unfilled lanes stay zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_idx_r         <= 2'd0;
      pk_word_r        <= 32'h0000_0000;
      out_word_r       <= 32'h0000_0000;
      out_word_valid_r <= 1'b0;
      out_row_done_r   <= 1'b0;
    end else begin
      out_word_valid_r <= 1'b0;
      out_row_done_r   <= 1'b0;
      if (flush_s) begin
        out_word_r       <= merged_s;
        out_word_valid_r <= 1'b1;
        out_row_done_r   <= s3_last_r;
        pk_word_r        <= 32'h0000_0000;
        pk_idx_r         <= 2'd0;
      end else if (s3_v_r) begin
        pk_word_r <= merged_s;
        pk_idx_r  <= pk_idx_r + 2'd1;
      end
    end
  end

  assign w_ready        = w_ready_r;
  assign out_word       = out_word_r;
  assign out_word_valid = out_word_valid_r;
  assign out_row_done   = out_row_done_r;
  assign busy           = s1_v_r | s2_v_r | s3_v_r | (pk_idx_r != 2'd0);

endmodule
